// File: rtl/touch_multi_ctrl_led.sv
// Multi-channel touch-key front end: sync, debounce and press detect
// per channel, then toggle / momentary / long-press / blink LED modes.
module touch_multi_ctrl_led #(
   parameter int unsigned CH_NUM    = 4,
   parameter int unsigned DEB_CNT   = 1_000_000,
   parameter int unsigned LONG_CNT  = 50_000_000,
   parameter int unsigned BLINK_CNT = 12_500_000,
   parameter logic        TOUCH_ACT = 1'b0
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [CH_NUM-1:0]   touch_key,
   input  logic [2*CH_NUM-1:0] mode,
   output logic [CH_NUM-1:0]   led,
   output logic [CH_NUM-1:0]   press_evt
);

   localparam int unsigned DW = $clog2(DEB_CNT);
   localparam int unsigned HW = $clog2(LONG_CNT + 1);
   localparam int unsigned BW = $clog2(BLINK_CNT);

   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CNT - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CNT);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CNT - 1);
   localparam logic [BW-1:0] BLK_MAX   = BW'(BLINK_CNT - 1);
   localparam logic          IDLE      = ~TOUCH_ACT;

   localparam logic [1:0] M_TOG   = 2'b00;
   localparam logic [1:0] M_MOM   = 2'b01;
   localparam logic [1:0] M_LONG  = 2'b10;
   localparam logic [1:0] M_BLINK = 2'b11;

   logic [CH_NUM-1:0]   sync1_q, sync2_q;
   logic [CH_NUM-1:0]   deb_lvl_q, deb_lvl_d;
   logic [DW-1:0]       deb_cnt_q [CH_NUM];
   logic [DW-1:0]       deb_cnt_d [CH_NUM];
   logic [HW-1:0]       hold_q [CH_NUM];
   logic [HW-1:0]       hold_d [CH_NUM];
   logic [CH_NUM-1:0]   pr_prev_q, evt_q, evt_d;
   logic [CH_NUM-1:0]   state_q, state_d;
   logic [CH_NUM-1:0]   en_q, en_d;
   logic [CH_NUM-1:0]   led_q, led_d;
   logic [2*CH_NUM-1:0] mode_prev_q;
   logic [BW-1:0]       blk_cnt_q, blk_cnt_d;
   logic                wave_q, wave_d;

   logic [CH_NUM-1:0]   pressed, rise, chg, fire;

   always_comb begin
      blk_cnt_d = blk_cnt_q + BW'(1);
      wave_d    = wave_q;
      if (blk_cnt_q == BLK_MAX) begin
         blk_cnt_d = '0;
         wave_d    = ~wave_q;
      end
   end

   always_comb begin
      deb_lvl_d = deb_lvl_q;
      pressed   = '0;
      rise      = '0;
      chg       = '0;
      fire      = '0;
      state_d   = state_q;
      en_d      = en_q;
      led_d     = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_lvl_q[i]) begin
            if (deb_cnt_q[i] == DEB_MAX)
               deb_lvl_d[i] = sync2_q[i];
            else
               deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
         end

         pressed[i] = (deb_lvl_q[i] == TOUCH_ACT);
         rise[i]    = pressed[i] & ~pr_prev_q[i];
         chg[i]     = mode[2*i +: 2] != mode_prev_q[2*i +: 2];

         // hold saturates, so LONG_CNT-1 is passed once per press
         hold_d[i] = '0;
         if (pressed[i])
            hold_d[i] = (hold_q[i] == HOLD_SAT) ? hold_q[i]
                                                : hold_q[i] + HW'(1);
         fire[i] = pressed[i] && (hold_q[i] == HOLD_FIRE);

         if (chg[i]) begin
            state_d[i] = 1'b0;
            en_d[i]    = 1'b0;
         end else begin
            unique case (mode[2*i +: 2])
               M_TOG:   state_d[i] = state_q[i] ^ rise[i];
               M_MOM:   state_d[i] = state_q[i];
               M_LONG:  state_d[i] = state_q[i] ^ fire[i];
               M_BLINK: en_d[i]    = en_q[i] ^ rise[i];
               default: state_d[i] = state_q[i];
            endcase
         end

         if (!chg[i]) begin
            unique case (mode[2*i +: 2])
               M_TOG:   led_d[i] = state_d[i];
               M_MOM:   led_d[i] = pressed[i];
               M_LONG:  led_d[i] = state_d[i];
               M_BLINK: led_d[i] = en_d[i] & wave_d;
               default: led_d[i] = 1'b0;
            endcase
         end
      end
      evt_d = rise;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sync1_q     <= {CH_NUM{IDLE}};
         sync2_q     <= {CH_NUM{IDLE}};
         deb_lvl_q   <= {CH_NUM{IDLE}};
         pr_prev_q   <= '0;
         evt_q       <= '0;
         state_q     <= '0;
         en_q        <= '0;
         led_q       <= '0;
         mode_prev_q <= mode;
         blk_cnt_q   <= '0;
         wave_q      <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) begin
            deb_cnt_q[i] <= '0;
            hold_q[i]    <= '0;
         end
      end else begin
         sync1_q     <= touch_key;
         sync2_q     <= sync1_q;
         deb_lvl_q   <= deb_lvl_d;
         pr_prev_q   <= pressed;
         evt_q       <= evt_d;
         state_q     <= state_d;
         en_q        <= en_d;
         led_q       <= led_d;
         mode_prev_q <= mode;
         blk_cnt_q   <= blk_cnt_d;
         wave_q      <= wave_d;
         for (int i = 0; i < CH_NUM; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            hold_q[i]    <= hold_d[i];
         end
      end
   end

   assign led       = led_q;
   assign press_evt = evt_q;

endmodule

// File: tb/tb_touch_multi_ctrl_led.sv
// Bench for touch_multi_ctrl_led: directed scenarios plus random
// key/mode activity, checked every cycle against a window-based model.
module tb_touch_multi_ctrl_led;

   localparam int   CH   = 2;
   localparam int   DEB  = 4;
   localparam int   LONG = 20;
   localparam int   BLK  = 5;
   localparam logic ACT  = 1'b0;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic [CH-1:0]   touch_key = '1;
   logic [2*CH-1:0] mode = '0;
   logic [CH-1:0]   led, press_evt;

   int n_cmp = 0;
   int n_bad = 0;
   int evt_cnt [CH];

   // reference model state
   int            cyc = 0;
   int            rst_cyc = 0;
   logic          hist [CH][DEB+2];
   logic [CH-1:0] m_deb, m_pr, m_pr1, m_state, m_en, m_led, m_evt;
   logic [1:0]    m_mprev [CH];
   int            m_start [CH];

   touch_multi_ctrl_led #(
      .CH_NUM(CH), .DEB_CNT(DEB), .LONG_CNT(LONG),
      .BLINK_CNT(BLK), .TOUCH_ACT(ACT)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .touch_key(touch_key), .mode(mode),
      .led(led), .press_evt(press_evt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // State after this edge, from inputs seen at the edge.
   task automatic model_edge();
      logic [1:0] md;
      logic       wv, rs, fr, ch_m, flip;
      cyc++;
      if (!sys_rst_n) begin
         rst_cyc = cyc;
         for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < DEB+2; j++) hist[c][j] = ~ACT;
            m_mprev[c] = mode[2*c +: 2];
            m_start[c] = 0;
         end
         m_deb = {CH{~ACT}};
         m_pr = '0; m_pr1 = '0; m_state = '0;
         m_en = '0; m_led = '0; m_evt = '0;
         return;
      end
      wv = 1'(((cyc - rst_cyc) / BLK) % 2);
      for (int c = 0; c < CH; c++) begin
         md   = mode[2*c +: 2];
         ch_m = (md != m_mprev[c]);
         rs   = m_pr[c] && !m_pr1[c];
         fr   = m_pr[c] && ((cyc - 1 - m_start[c]) == LONG - 1);
         if (ch_m) begin
            m_state[c] = 1'b0;
            m_en[c]    = 1'b0;
         end else begin
            if (md == 2'd0 && rs) m_state[c] = ~m_state[c];
            if (md == 2'd2 && fr) m_state[c] = ~m_state[c];
            if (md == 2'd3 && rs) m_en[c] = ~m_en[c];
         end
         if (ch_m)            m_led[c] = 1'b0;
         else if (md == 2'd1) m_led[c] = m_pr[c];
         else if (md == 2'd3) m_led[c] = m_en[c] & wv;
         else                 m_led[c] = m_state[c];
         m_evt[c]   = rs;
         m_mprev[c] = md;
         // level accepted once DEB_CNT synchronised samples all differ
         for (int j = DEB+1; j > 0; j--) hist[c][j] = hist[c][j-1];
         hist[c][0] = touch_key[c];
         flip = 1'b1;
         for (int j = 2; j < DEB+2; j++)
            if (hist[c][j] == m_deb[c]) flip = 1'b0;
         if (flip) m_deb[c] = ~m_deb[c];
         m_pr1[c] = m_pr[c];
         m_pr[c]  = (m_deb[c] == ACT);
         if (m_pr[c] && !m_pr1[c]) m_start[c] = cyc;
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      chk("led", 32'(led), 32'(m_led));
      chk("press_evt", 32'(press_evt), 32'(m_evt));
      for (int c = 0; c < CH; c++)
         if (press_evt[c]) evt_cnt[c]++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clr_cnt();
      for (int c = 0; c < CH; c++) evt_cnt[c] = 0;
   endtask

   initial begin
      int lat, run, rises;
      logic pv, first;
      clr_cnt();
      @(negedge sys_clk);

      sys_rst_n = 1'b0;
      step();
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_evt", 32'(press_evt), 32'd0);
      sys_rst_n = 1'b1;
      steps(5);

      // toggle: two presses, 7-cycle latency
      clr_cnt();
      lat = 0;
      touch_key[0] = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (press_evt[0] && lat == 0) lat = i;
      end
      chk("tog_lat", 32'(lat), 32'd7);
      chk("tog_led1", 32'(led[0]), 32'd1);
      touch_key[0] = 1'b1; steps(15);
      touch_key[0] = 1'b0; steps(15);
      touch_key[0] = 1'b1; steps(15);
      chk("tog_evts", 32'(evt_cnt[0]), 32'd2);
      chk("tog_led0", 32'(led[0]), 32'd0);

      // glitch rejection boundary
      clr_cnt();
      touch_key[0] = 1'b0; steps(3);
      touch_key[0] = 1'b1; steps(15);
      chk("glitch3_evt", 32'(evt_cnt[0]), 32'd0);
      chk("glitch3_led", 32'(led[0]), 32'd0);
      touch_key[0] = 1'b0; steps(4);
      touch_key[0] = 1'b1; steps(15);
      chk("glitch4_evt", 32'(evt_cnt[0]), 32'd1);
      chk("glitch4_led", 32'(led[0]), 32'd1);

      // long-press on ch1
      mode[3:2] = 2'b10; steps(2);
      clr_cnt();
      touch_key[1] = 1'b0; steps(10);
      touch_key[1] = 1'b1; steps(15);
      chk("short_evt", 32'(evt_cnt[1]), 32'd1);
      chk("short_led", 32'(led[1]), 32'd0);
      rises = 0; pv = led[1];
      touch_key[1] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (led[1] && !pv) rises++;
         pv = led[1];
      end
      touch_key[1] = 1'b1; steps(15);
      chk("long_once", 32'(rises), 32'd1);
      chk("long_led1", 32'(led[1]), 32'd1);
      touch_key[1] = 1'b0; steps(30);
      touch_key[1] = 1'b1; steps(15);
      chk("long_led0", 32'(led[1]), 32'd0);

      // blink on ch1, momentary on ch0
      mode = 4'b1101; steps(3);
      touch_key = 2'b00; steps(10);
      touch_key[1] = 1'b1;
      run = 0; first = 1'b1; pv = led[1];
      for (int i = 0; i < 40; i++) begin
         step();
         if (led[1] != pv) begin
            if (!first) chk("blink_run", 32'(run), 32'd5);
            first = 1'b0;
            run = 1;
         end else begin
            run++;
         end
         pv = led[1];
      end
      chk("mom_on", 32'(led[0]), 32'd1);
      touch_key = 2'b01; steps(12);
      touch_key = 2'b11; steps(10);
      chk("blink_off", 32'(led[1]), 32'd0);
      chk("mom_off", 32'(led[0]), 32'd0);

      // mode change clears led
      mode = 4'b1100; steps(2);
      touch_key[0] = 1'b0; steps(10);
      touch_key[0] = 1'b1; steps(10);
      chk("sw_pre", 32'(led[0]), 32'd1);
      mode = 4'b1101; step();
      chk("sw_clr", 32'(led[0]), 32'd0);

      // reset during a held press
      mode = 4'b1100; steps(2);
      touch_key[0] = 1'b0; steps(10);
      sys_rst_n = 1'b0; step();
      chk("rst2_led", 32'(led), 32'd0);
      chk("rst2_evt", 32'(press_evt), 32'd0);
      step();
      sys_rst_n = 1'b1; steps(2);
      touch_key[0] = 1'b1;
      clr_cnt(); steps(20);
      chk("rst_noevt", 32'(evt_cnt[0]), 32'd0);

      // random activity
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 11) == 0) touch_key[c] = ~touch_key[c];
            if ($urandom_range(0, 149) == 0)
               mode[2*c +: 2] = 2'($urandom_range(0, 3));
         end
         sys_rst_n = ($urandom_range(0, 799) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/touch_multi_ctrl_led.md
# touch_multi_ctrl_led

Parametrised, multi-channel successor to the single touch-key LED toggler. Each of CH_NUM touch-key inputs is synchronised, debounced and decoded into one of four per-channel LED behaviours: toggle, momentary, long-press toggle, or blink-enable. The block sits between the board touch-pad pins and the LED pins and runs entirely in the sys_clk domain.

## Interface
- CH_NUM, 4: number of independent touch/LED channels (1..16)
- DEB_CNT, 1_000_000: consecutive stable cycles required to accept a level change (>=2)
- LONG_CNT, 50_000_000: held cycles that qualify as a long press (>DEB_CNT)
- BLINK_CNT, 12_500_000: half-period of the shared blink square wave, in cycles (>=2)
- TOUCH_ACT, 1'b0: input level meaning "touched"
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  synchronous active-low reset (sampled on sys_clk rising edge)
- touch_key  input  CH_NUM  raw asynchronous touch-pad levels, idle = ~TOUCH_ACT
- mode  input  2*CH_NUM  per-channel mode, bits [2i+1:2i] for channel i: 00 toggle, 01 momentary, 10 long-press toggle, 11 blink-enable
- led  output  CH_NUM  LED drive, 1 = on
- press_evt  output  CH_NUM  one-cycle pulse per accepted press, per channel

## Operation
- Per channel: 2-flop synchroniser -> debouncer -> press-edge detector -> mode logic. One shared blink generator.
- Debouncer: counter deb_cnt (width $clog2(DEB_CNT)) increments each cycle the synchronised level differs from the debounced level; clears to 0 whenever they match. When deb_cnt == DEB_CNT-1 and levels still differ, debounced level takes the synchronised level and deb_cnt clears. Glitches shorter than DEB_CNT cycles are discarded.
- pressed = (debounced level == TOUCH_ACT). press_evt[i] = registered rising edge of pressed.
- Hold counter per channel: counts while pressed, saturates at LONG_CNT, clears when released.
- Mode 00 toggle: led state inverts on each press_evt.
- Mode 01 momentary: led = pressed (registered).
- Mode 10 long-press: led state inverts when hold counter reaches LONG_CNT-1; at most one inversion per press; short presses do nothing (press_evt still pulses).
- Mode 11 blink-enable: enable bit inverts on each press_evt; led = enable & blink_wave.
- Blink generator: counter 0..BLINK_CNT-1; blink_wave inverts at wrap. Free-running, shared by all channels.
- Mode change: any cycle where mode[i] differs from its previous-cycle value clears channel i led state and enable on the next edge; debouncer and hold counter unaffected.
- Channels fully independent; simultaneous presses on any subset all take effect in the same cycle.

## Timing
- Reset (sys_rst_n low at a rising edge): led = 0, press_evt = 0, synchroniser flops and debounced level = ~TOUCH_ACT, all counters 0, blink_wave 0, previous-mode register = current mode. Reset mid-press discards the press; no event after release.
- Latency: input change at edge E is in sync stage 2 at E+2; debounced level updates at E+2+DEB_CNT; press_evt high during cycle after E+3+DEB_CNT edge (one cycle wide); toggle/blink-enable led change on same edge press_evt asserts; momentary led follows pressed with the same 1-cycle register delay.
- Long-press inversion: LONG_CNT cycles after debounced press (+1 register).
- Release edges never produce press_evt.
- Blink: led in mode 11 changes every BLINK_CNT cycles; enabling mid-period shows the current phase immediately.

## Test plan
- Params CH_NUM=2, DEB_CNT=4, LONG_CNT=20, BLINK_CNT=5, TOUCH_ACT=0. Reset 1 cycle -> led=00, press_evt=00 throughout reset.
- Ch0 mode 00, touch_key[0] low 15 cycles, high, low 15 cycles -> press_evt[0] pulses twice (each 1 cycle, 7 cycles after falling edge); led[0] 0->1->0.
- Ch0 glitch low 3 cycles -> no press_evt, led unchanged; glitch 4 cycles -> accepted.
- Ch1 mode 10, hold 10 cycles -> press_evt, led[1] stays 0; hold 30 cycles -> led[1]=1 exactly once; release/repress long -> led[1]=0.
- Ch1 mode 11 press -> led[1] square wave, 5 cycles high/5 low; second press -> led[1]=0; ch0 mode 01 concurrently tracks held key.
- Ch0 led=1 in mode 00, switch mode to 01 -> led[0]=0 next cycle; assert reset during held press -> no event after reset release.
